uart_tx: RTL and testbench

Byte-wide UART transmitter for the high-speed sampling link: 8 data bits, no parity, 1 or 2 stop bits, LSB first, line idle high. It is the transmit-side partner of the existing UART receiver and uses the same baud-tick scheme (460800 baud by default, one-cycle enable per bit period). A small internal FIFO accepts a burst of words from the sample/command logic and sends them back-to-back on the serial line.

---
 rtl/uart_tx_if.sv | 9 +
 rtl/uart_tx.sv | 142 ++++++++++++++
 tb/tb_uart_tx.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// Write-side handshake between the sample/command logic and the UART transmitter FIFO.
interface uart_tx_if;
  logic       i_TX_en;
  logic [7:0] i_TX_word;
  logic       o_TX_ready;

  modport master (output i_TX_en, output i_TX_word, input o_TX_ready);
  modport slave  (input i_TX_en, input i_TX_word, output o_TX_ready);
endinterface

// File: rtl/uart_tx.sv
// Byte UART transmitter: 8N1/8N2, LSB first, idle high, fed by a small word FIFO.
//
// state | meaning
// IDLE  | line high, waiting for a tick with a queued word
// START | driving the start bit (low)
// DATA  | driving data bits 0..7, LSB first
// STOP  | driving STOP_BITS stop periods; may chain straight into the next START
module uart_tx #(
  parameter int FIFO_DEPTH = 4,
  parameter int STOP_BITS  = 1
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     i_BAUD_EN,
  uart_tx_if.slave tx,
  output logic     o_TX_B,
  output logic     o_busy,
  output logic     o_TX_done
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nxt;
  logic [7:0]    shift;
  logic [2:0]    bit_idx;
  logic          stop_cnt;
  logic          wr, load, pop;

  assign wr = tx.i_TX_en && tx.o_TX_ready;

  // Pop decision uses the count from the start of the cycle, so a word written
  // in this same cycle can never be the one popped.
  always_comb begin
    load = 1'b0;
    if (i_BAUD_EN) begin
      case (state)
        IDLE:    load = 1'b1;
        STOP:    load = (stop_cnt == LAST_STOP);
        default: load = 1'b0;
      endcase
    end
    pop = load && (count != '0);
    count_nxt = count;
    if (wr && !pop)
      count_nxt = count + CW'(1);
    else if (!wr && pop)
      count_nxt = count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (wr)
      mem[wr_ptr] <= tx.i_TX_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      tx.o_TX_ready <= 1'b1;
    end else begin
      if (wr)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      count         <= count_nxt;
      tx.o_TX_ready <= (count_nxt < DEPTH_C);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shift     <= '0;
      bit_idx   <= '0;
      stop_cnt  <= 1'b0;
      o_TX_B    <= 1'b1;
      o_busy    <= 1'b0;
      o_TX_done <= 1'b0;
    end else begin
      o_TX_done <= 1'b0;
      if (i_BAUD_EN) begin
        case (state)
          IDLE: begin
            if (pop) begin
              shift  <= mem[rd_ptr];
              state  <= START;
              o_TX_B <= 1'b0;
              o_busy <= 1'b1;
            end
          end
          START: begin
            state   <= DATA;
            bit_idx <= '0;
            o_TX_B  <= shift[0];
          end
          DATA: begin
            if (bit_idx == 3'd7) begin
              state    <= STOP;
              stop_cnt <= 1'b0;
              o_TX_B   <= 1'b1;
            end else begin
              shift   <= {1'b0, shift[7:1]};
              bit_idx <= bit_idx + 3'd1;
              o_TX_B  <= shift[1];
            end
          end
          STOP: begin
            if (load) begin
              o_TX_done <= 1'b1;
              // Chaining straight to START keeps o_busy high with no idle gap.
              if (pop) begin
                shift  <= mem[rd_ptr];
                state  <= START;
                o_TX_B <= 1'b0;
              end else begin
                state  <= IDLE;
                o_busy <= 1'b0;
              end
            end else begin
              stop_cnt <= stop_cnt + 1'b1;
            end
          end
          default: begin
            state  <= IDLE;
            o_TX_B <= 1'b1;
            o_busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: waveform, back-to-back, FIFO full, write/pop collisions, reset, loopback.
module tb_uart_tx;

  logic clk = 1'b0;
  logic rst;
  logic i_BAUD_EN;
  logic o_TX_B, o_busy, o_TX_done;

  uart_tx_if bus();

  uart_tx #(.FIFO_DEPTH(4), .STOP_BITS(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_BAUD_EN (i_BAUD_EN),
    .tx        (bus),
    .o_TX_B    (o_TX_B),
    .o_busy    (o_busy),
    .o_TX_done (o_TX_done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int per = 0;
  int bcnt = 0;

  int cyc = 0;
  int done_cnt = 0;
  int busy_falls = 0;
  int frame_err = 0;
  logic prev_busy = 1'b0;
  int rx_busy = 0;
  int rx_bit = 0;
  int rx_cnt = 0;
  logic [7:0] rx_sh = '0;
  logic [7:0] rxq[$];
  int starts[$];

  // Line monitor: mid-bit sampling receiver model driven by the bench's own tick period.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (rst) begin
      rx_busy   = 0;
      prev_busy = 1'b0;
    end else begin
      if (o_TX_done) done_cnt++;
      if (prev_busy && !o_busy) busy_falls++;
      prev_busy = o_busy;
      if (rx_busy == 0 && o_TX_B === 1'b0 && per > 0) begin
        rx_busy = 1;
        rx_bit  = 0;
        rx_cnt  = per / 2;
        starts.push_back(cyc);
      end
      if (rx_busy != 0) begin
        if (rx_cnt == 0) begin
          rx_cnt = per - 1;
          if (rx_bit == 0) begin
            if (o_TX_B !== 1'b0) frame_err++;
          end else if (rx_bit <= 8) begin
            rx_sh = {o_TX_B, rx_sh[7:1]};
          end else begin
            if (o_TX_B !== 1'b1) frame_err++;
            rxq.push_back(rx_sh);
            rx_busy = 0;
          end
          rx_bit++;
        end else begin
          rx_cnt--;
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    bus.i_TX_en = 1'b0;
    if (per == 0) begin
      i_BAUD_EN = 1'b0;
    end else begin
      i_BAUD_EN = (bcnt == 0);
      bcnt = (bcnt + 1 == per) ? 0 : bcnt + 1;
    end
  endtask

  task automatic put(input logic [7:0] v);
    step();
    bus.i_TX_en   = 1'b1;
    bus.i_TX_word = v;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_rx(input int n, input int limit);
    int k;
    k = 0;
    while (rxq.size() < n && k < limit) begin
      step();
      k++;
    end
    n_chk++;
    if (rxq.size() < n) $display("FAIL wait_rx: got %0d frames, need %0d", rxq.size(), n);
    else n_pass++;
  endtask

  task automatic wait_low(input int limit);
    int k;
    k = 0;
    while (o_TX_B !== 1'b0 && k < limit) begin
      step();
      k++;
    end
    n_chk++;
    if (o_TX_B !== 1'b0) $display("FAIL wait_start: line %b, need 0 within %0d cycles", o_TX_B, limit);
    else n_pass++;
  endtask

  task automatic clear_logs();
    rxq.delete();
    starts.delete();
  endtask

  task automatic test_reset();
    per = 0;
    step();
    n_chk++; if (o_TX_B !== 1'b1) $display("FAIL rst_line: got %b want 1", o_TX_B); else n_pass++;
    n_chk++; if (bus.o_TX_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", bus.o_TX_ready); else n_pass++;
    n_chk++; if (o_busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", o_busy); else n_pass++;
    n_chk++; if (o_TX_done !== 1'b0) $display("FAIL rst_done: got %b want 0", o_TX_done); else n_pass++;
    rst = 1'b0;
    idle(5);
    n_chk++; if (o_TX_B !== 1'b1) $display("FAIL post_rst_line: got %b want 1", o_TX_B); else n_pass++;
    n_chk++; if (o_busy !== 1'b0) $display("FAIL post_rst_busy: got %b want 0", o_busy); else n_pass++;
  endtask

  task automatic test_single();
    logic [9:0] fr;
    int bad_line, bad_busy, bad_done;
    fr = {1'b1, 8'hA5, 1'b0};
    bad_line = 0; bad_busy = 0; bad_done = 0;
    clear_logs();
    per = 4; bcnt = 0;
    put(8'hA5);
    step();
    wait_low(20);
    for (int k = 0; k < 40; k++) begin
      if (o_TX_B !== fr[k/4]) begin
        bad_line++;
        $display("FAIL single_line k=%0d: got %b want %b", k, o_TX_B, fr[k/4]);
      end
      if (o_busy !== 1'b1) bad_busy++;
      if (o_TX_done !== 1'b0) bad_done++;
      step();
    end
    n_chk++; if (bad_line != 0) $display("FAIL single_wave: %0d bad samples, want 0", bad_line); else n_pass++;
    n_chk++; if (bad_busy != 0) $display("FAIL single_busy: %0d low samples, want 0", bad_busy); else n_pass++;
    n_chk++; if (bad_done != 0) $display("FAIL single_early_done: %0d pulses, want 0", bad_done); else n_pass++;
    n_chk++; if (o_TX_done !== 1'b1) $display("FAIL single_done_at_40: got %b want 1", o_TX_done); else n_pass++;
    n_chk++; if (o_busy !== 1'b0) $display("FAIL single_busy_end: got %b want 0", o_busy); else n_pass++;
    n_chk++; if (o_TX_B !== 1'b1) $display("FAIL single_idle_line: got %b want 1", o_TX_B); else n_pass++;
    step();
    n_chk++; if (o_TX_done !== 1'b0) $display("FAIL single_done_width: got %b want 0", o_TX_done); else n_pass++;
    idle(10);
  endtask

  task automatic test_latency();
    clear_logs();
    per = 1; bcnt = 0;
    put(8'h81);
    step();
    n_chk++; if (o_TX_B !== 1'b1) $display("FAIL lat_n1: got %b want 1", o_TX_B); else n_pass++;
    step();
    n_chk++; if (o_TX_B !== 1'b0) $display("FAIL lat_n2_start: got %b want 0", o_TX_B); else n_pass++;
    n_chk++; if (o_busy !== 1'b1) $display("FAIL lat_n2_busy: got %b want 1", o_busy); else n_pass++;
    wait_rx(1, 50);
    n_chk++; if (rxq.size() < 1 || rxq[0] !== 8'h81) $display("FAIL lat_byte: got %0d frames, want one 0x81", rxq.size()); else n_pass++;
    idle(10);
  endtask

  task automatic test_back_to_back();
    int d0, b0;
    clear_logs();
    per = 4; bcnt = 0;
    d0 = done_cnt; b0 = busy_falls;
    put(8'h00);
    put(8'hFF);
    wait_rx(2, 200);
    idle(10);
    n_chk++; if (rxq.size() != 2 || rxq[0] !== 8'h00 || rxq[1] !== 8'hFF)
      $display("FAIL b2b_bytes: got %0d frames, want 00 then FF", rxq.size()); else n_pass++;
    n_chk++; if (starts.size() != 2 || starts[1] - starts[0] != 40)
      $display("FAIL b2b_gap: start spacing %0d, want 40", (starts.size() == 2) ? starts[1] - starts[0] : -1); else n_pass++;
    n_chk++; if (done_cnt - d0 != 2) $display("FAIL b2b_done: got %0d pulses want 2", done_cnt - d0); else n_pass++;
    n_chk++; if (busy_falls - b0 != 1) $display("FAIL b2b_busy: got %0d falls want 1", busy_falls - b0); else n_pass++;
  endtask

  task automatic test_fifo_full();
    clear_logs();
    per = 0;
    put(8'h11);
    put(8'h22);
    put(8'h33);
    n_chk++; if (bus.o_TX_ready !== 1'b1) $display("FAIL full_ready_3: got %b want 1", bus.o_TX_ready); else n_pass++;
    put(8'h44);
    put(8'h55);
    n_chk++; if (bus.o_TX_ready !== 1'b0) $display("FAIL full_ready_4: got %b want 0", bus.o_TX_ready); else n_pass++;
    idle(5);
    n_chk++; if (o_TX_B !== 1'b1) $display("FAIL full_no_tick_line: got %b want 1", o_TX_B); else n_pass++;
    per = 4; bcnt = 0;
    wait_rx(4, 400);
    idle(100);
    n_chk++; if (rxq.size() != 4 || rxq[0] !== 8'h11 || rxq[1] !== 8'h22 || rxq[2] !== 8'h33 || rxq[3] !== 8'h44)
      $display("FAIL full_order: got %0d frames, want 11 22 33 44 only", rxq.size()); else n_pass++;
  endtask

  task automatic test_simultaneous();
    clear_logs();
    per = 0;
    put(8'hA1);
    put(8'hA2);
    put(8'hA3);
    put(8'hA4);
    step();
    n_chk++; if (bus.o_TX_ready !== 1'b0) $display("FAIL sim4_ready_full: got %b want 0", bus.o_TX_ready); else n_pass++;
    per = 4; bcnt = 0;
    put(8'h99);
    step();
    n_chk++; if (bus.o_TX_ready !== 1'b1) $display("FAIL sim4_ready_after_pop: got %b want 1", bus.o_TX_ready); else n_pass++;
    wait_rx(4, 400);
    idle(100);
    n_chk++; if (rxq.size() != 4 || rxq[0] !== 8'hA1 || rxq[1] !== 8'hA2 || rxq[2] !== 8'hA3 || rxq[3] !== 8'hA4)
      $display("FAIL sim4_refused: got %0d frames, want A1..A4 without 99", rxq.size()); else n_pass++;

    clear_logs();
    per = 0;
    put(8'h3C);
    step();
    per = 4; bcnt = 0;
    put(8'hC3);
    wait_rx(2, 200);
    idle(100);
    n_chk++; if (rxq.size() != 2 || rxq[0] !== 8'h3C || rxq[1] !== 8'hC3)
      $display("FAIL sim1_next_frame: got %0d frames, want 3C then C3", rxq.size()); else n_pass++;
  endtask

  task automatic test_reset_midframe();
    clear_logs();
    per = 4; bcnt = 0;
    put(8'h5A);
    put(8'h11);
    put(8'h22);
    step();
    wait_low(20);
    idle(18);
    rst = 1'b1;
    #1;
    n_chk++; if (o_TX_B !== 1'b1) $display("FAIL mid_rst_line: got %b want 1", o_TX_B); else n_pass++;
    n_chk++; if (bus.o_TX_ready !== 1'b1) $display("FAIL mid_rst_ready: got %b want 1", bus.o_TX_ready); else n_pass++;
    n_chk++; if (o_busy !== 1'b0) $display("FAIL mid_rst_busy: got %b want 0", o_busy); else n_pass++;
    idle(3);
    clear_logs();
    rst = 1'b0;
    idle(150);
    n_chk++; if (starts.size() != 0 || rxq.size() != 0)
      $display("FAIL mid_rst_no_frame: got %0d starts, want 0", starts.size()); else n_pass++;
    n_chk++; if (o_TX_B !== 1'b1) $display("FAIL mid_rst_idle_line: got %b want 1", o_TX_B); else n_pass++;
    put(8'hE7);
    wait_rx(1, 200);
    idle(100);
    n_chk++; if (rxq.size() != 1 || rxq[0] !== 8'hE7)
      $display("FAIL mid_rst_new_word: got %0d frames, want only E7", rxq.size()); else n_pass++;
  endtask

  task automatic test_loopback();
    int sent, guard, d0, bad;
    clear_logs();
    per = 4; bcnt = 0;
    d0 = done_cnt;
    frame_err = 0;
    sent = 0; guard = 0; bad = 0;
    while (sent < 256 && guard < 20000) begin
      step();
      guard++;
      if (bus.o_TX_ready === 1'b1) begin
        bus.i_TX_en   = 1'b1;
        bus.i_TX_word = sent[7:0];
        sent++;
      end
    end
    wait_rx(256, 2000);
    idle(50);
    for (int i = 0; i < 256 && i < rxq.size(); i++) begin
      if (rxq[i] !== i[7:0]) begin
        bad++;
        $display("FAIL loop_byte %0d: got %h want %h", i, rxq[i], i[7:0]);
      end
    end
    n_chk++; if (bad != 0) $display("FAIL loop_data: %0d wrong bytes, want 0", bad); else n_pass++;
    n_chk++; if (rxq.size() != 256) $display("FAIL loop_count: got %0d frames want 256", rxq.size()); else n_pass++;
    n_chk++; if (frame_err != 0) $display("FAIL loop_framing: got %0d errors want 0", frame_err); else n_pass++;
    n_chk++; if (done_cnt - d0 != 256) $display("FAIL loop_done: got %0d pulses want 256", done_cnt - d0); else n_pass++;
  endtask

  initial begin
    rst           = 1'b1;
    i_BAUD_EN     = 1'b0;
    bus.i_TX_en   = 1'b0;
    bus.i_TX_word = '0;
    repeat (3) @(negedge clk);
    test_reset();
    test_single();
    test_latency();
    test_back_to_back();
    test_fifo_full();
    test_simultaneous();
    test_reset_midframe();
    test_loopback();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
